bus_wait: RTL and testbench
===========================

Name: bus_wait

Overview:
- Memory bridge directly upstream of the control sequencer.
- Converts the core's per-cycle bus (AB, WE, DO, sync) into a req/ack handshake to slow or external memory.
- Produces the core's rdy and registered DB; DB feeds the opcode lookup and datapath.
- Stalls the sequencer while an access is outstanding. Aborts hung accesses with a timeout and a sticky error flag.

Parameters:
- ADDR_W, 16, core/memory address width
- DATA_W, 8, data width
- TIMEOUT, 255, cycles to wait for mem_ack before aborting (1..255)
- ERR_DATA, 8'hFF, DB value returned on timeout

Ports:
- clk  in  1  global clock
- reset  in  1  synchronous, active-low reset
- AB  in  ADDR_W  core address for current cycle
- WE  in  1  core write enable
- DO  in  DATA_W  core write data
- sync  in  1  core opcode-fetch marker
- rdy_in  in  1  top-level RDY input
- rdy  out  1  advance enable to core/sequencer
- DB  out  DATA_W  registered read data to core
- mem_req  out  1  access request, held until ack
- mem_we  out  1  write qualifier
- mem_fetch  out  1  access is an opcode fetch
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory completion, single-cycle pulse
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- bus_err  out  1  sticky timeout flag
- err_clr  in  1  clears bus_err

Behaviour:
- Clocking and reset: one clock domain. All state changes on posedge clk. Reset is sampled only at posedge (reset==0).
- States: READY, WAIT.
- Reset values: state=READY, DB=0, mem_req=0, mem_we=0, mem_fetch=0, mem_addr=0, mem_wdata=0, bus_err=0, timer=0.
- rdy = (state==READY) & rdy_in. This path is combinational; nothing else is combinational to outputs.
- READY with rdy==1 at the edge:
  - capture AB→mem_addr, WE→mem_we, DO→mem_wdata, sync→mem_fetch
  - mem_req←1, timer←0, state←WAIT
- READY with rdy_in==0: hold everything. DB stable, no request issued.
- WAIT, no ack:
  - rdy=0
  - all mem_* outputs held stable
  - timer increments, saturating
- WAIT with mem_ack==1:
  - for a read, DB←mem_rdata
  - for a write, DB unchanged
  - mem_req←0, state←READY
- Throughput and latency: a zero-wait memory (ack in first WAIT cycle) gives 2 clk per core cycle. N-cycle ack latency gives N+1 clk. DB is valid in the READY cycle in which rdy rises.
- Timeout: in WAIT, if timer==TIMEOUT-1 and mem_ack==0, then:
  - mem_req←0, state←READY, bus_err←1
  - for a read, DB←ERR_DATA; for a write, DB unchanged
- Ack on the timeout cycle: mem_ack wins, no error.
- mem_ack in READY: ignored (spurious). No state change, no DB update.
- err_clr==1 clears bus_err. If a timeout occurs in the same cycle, set wins (bus_err=1).
- Reset mid-access: mem_req drops at the next edge. A late ack after reset is ignored as spurious. Memory side must tolerate request withdrawal only on reset.
- rdy_in falling during WAIT has no effect on the access. rdy remains 0 until both the ack has arrived and rdy_in==1.
- Address/data width: no arithmetic on AB. Timer width is 8 bits.

Decomposition:
- Shared package bus_pkg:
  - state typedef (READY, WAIT)
  - default ERR_DATA constant
  - timer width constant (8)
- One natural sub-module: bus_timer. Saturating 8-bit counter with clear/enable and a terminal flag at TIMEOUT-1. It is reusable for the future interrupt-latency watchdog.

Test Plan:
- Zero-wait read: AB=16'hFFFC, WE=0, sync=0; mem_ack one cycle after mem_req with rdata=8'h34 → mem_addr=FFFC, DB=8'h34, rdy high exactly every 2nd clk.
- 3-wait opcode fetch: AB=16'h0200, sync=1; ack 3 cycles late with rdata=8'hA9 → mem_fetch=1, rdy low 3 clk, DB=8'hA9 on rdy rise, mem_addr stable throughout.
- Write: AB=16'h01FF, WE=1, DO=8'h5A, prior DB=8'h34 → mem_we=1, mem_wdata=8'h5A, DB stays 8'h34 after ack.
- rdy_in low: rdy_in=0 in READY for 4 clk → no mem_req, DB held. rdy_in=0 while ack arrives → state READY, rdy=0 until rdy_in=1.
- Timeout: TIMEOUT=4, read, no ack → mem_req drops after 4 WAIT cycles, DB=8'hFF, bus_err=1. err_clr=1 clears it. Repeat with ack on the 4th cycle → no error, DB=mem_rdata.
- Reset mid-access: reset=0 during WAIT → next edge mem_req=0, DB=0, bus_err=0. A subsequent mem_ack pulse causes no change.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus wait-state bridge.
// Holds the handshake FSM state type, the timer width used by the
// access watchdog, and the default data value returned to the core
// when an access is aborted.
package bus_pkg;

  // Width of the access watchdog counter.
  localparam int TIMER_W = 8;

  // Value driven onto DB when a read is aborted by the watchdog.
  localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

  // READY: core may advance, a new access is launched when rdy_in is high.
  // WAIT : an access is outstanding, the core is stalled.
  typedef enum logic {
    READY = 1'b0,
    WAIT  = 1'b1
  } busState_e;

endpackage

// File: rtl/bus_timer.sv
// Saturating watchdog counter.
// Counts enabled cycles since the last clear and flags when the count
// reaches TIMEOUT-1, so the owner can abort on the TIMEOUT-th cycle.
// Ports:
//   clk        clock
//   reset      synchronous active-low reset
//   clear_i    restart the count at zero (wins over enable)
//   enable_i   advance the count by one, sticking at all-ones
//   terminal_o high while the count equals TIMEOUT-1
module bus_timer
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Clear has priority; the count stops at all-ones instead of wrapping so
  // a long stall can never alias back into a small count.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_wait.sv
// Memory bridge between the core's per-cycle bus and a req/ack memory.
// Each core cycle launches one access and stalls the core (rdy low) until
// the memory acknowledges it or the watchdog aborts it.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   AB, WE, DO, sync      core address, write enable, write data, fetch marker
//   rdy_in                external ready; rdy_out = READY & rdy_in
//   rdy                   advance enable to the core (only combinational output)
//   DB                    registered read data returned to the core
//   mem_req               access request, held until ack or abort
//   mem_we, mem_fetch     captured write / opcode-fetch qualifiers
//   mem_addr, mem_wdata   captured address and write data
//   mem_ack, mem_rdata    single-cycle completion pulse and read data
//   bus_err, err_clr      sticky abort flag and its clear
module bus_wait
  import bus_pkg::*;
#(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 8,
  parameter int                 TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]  ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] AB,
  input  logic              WE,
  input  logic [DATA_W-1:0] DO,
  input  logic              sync,
  input  logic              rdy_in,
  output logic              rdy,
  output logic [DATA_W-1:0] DB,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_fetch,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err,
  input  logic              err_clr
);

  busState_e         state_q, state_d;
  logic [DATA_W-1:0] db_q, db_d;
  logic              memReq_q, memReq_d;
  logic              memWe_q, memWe_d;
  logic              memFetch_q, memFetch_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic              busErr_q, busErr_d;
  logic              timerClear;
  logic              timerEnable;
  logic              timerTerm;
  logic              timeout;

  assign rdy = (state_q == READY) & rdy_in;

  // The watchdog restarts when an access is launched and counts every
  // cycle spent waiting for the acknowledge.
  bus_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (timerClear),
    .enable_i  (timerEnable),
    .terminal_o(timerTerm)
  );

  // Handshake FSM. Captured request fields stay frozen between launches so
  // the memory sees a stable request for the whole access. An ack seen in
  // the terminal cycle completes the access normally, so it is checked
  // before the timeout. Acks in READY are spurious and fall through.
  always_comb begin
    state_d     = state_q;
    db_d        = db_q;
    memReq_d    = memReq_q;
    memWe_d     = memWe_q;
    memFetch_d  = memFetch_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    timerClear  = 1'b0;
    timerEnable = 1'b0;
    timeout     = 1'b0;

    case (state_q)
      READY: begin
        if (rdy_in) begin
          memAddr_d  = AB;
          memWe_d    = WE;
          memWdata_d = DO;
          memFetch_d = sync;
          memReq_d   = 1'b1;
          timerClear = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        timerEnable = 1'b1;
        if (mem_ack) begin
          if (!memWe_q) begin
            db_d = mem_rdata;
          end
          memReq_d = 1'b0;
          state_d  = READY;
        end else if (timerTerm) begin
          if (!memWe_q) begin
            db_d = ERR_DATA;
          end
          timeout  = 1'b1;
          memReq_d = 1'b0;
          state_d  = READY;
        end
      end
      default: begin
        state_d = READY;
      end
    endcase

    // A timeout in the same cycle as a clear leaves the flag set.
    busErr_d = busErr_q;
    if (err_clr) begin
      busErr_d = 1'b0;
    end
    if (timeout) begin
      busErr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= READY;
      db_q       <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memFetch_q <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      busErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_q       <= db_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memFetch_q <= memFetch_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      busErr_q   <= busErr_d;
    end
  end

  assign DB        = db_q;
  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_fetch = memFetch_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign bus_err   = busErr_q;

endmodule

// File: tb/tb_bus_wait.sv
// Directed testbench for bus_wait with a short watchdog (TIMEOUT=4).
// Each vector drives inputs after the falling edge, lets one rising edge
// pass, then compares all outputs 1 time unit later.
module tb_bus_wait;

  typedef struct packed {
    logic        rst;
    logic        rdyIn;
    logic [15:0] ab;
    logic        we;
    logic [7:0]  dout;
    logic        sync;
    logic        ack;
    logic [7:0]  rdata;
    logic        errClr;
    logic        eRdy;
    logic        eReq;
    logic        eWe;
    logic        eFetch;
    logic [15:0] eAddr;
    logic [7:0]  eWdata;
    logic [7:0]  eDb;
    logic        eErr;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] ab;
  logic        we;
  logic [7:0]  dout;
  logic        sync;
  logic        rdyIn;
  logic        rdy;
  logic [7:0]  db;
  logic        memReq;
  logic        memWe;
  logic        memFetch;
  logic [15:0] memAddr;
  logic [7:0]  memWdata;
  logic        memAck;
  logic [7:0]  rdata;
  logic        busErr;
  logic        errClr;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  bus_wait #(
    .ADDR_W  (16),
    .DATA_W  (8),
    .TIMEOUT (4),
    .ERR_DATA(8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .AB       (ab),
    .WE       (we),
    .DO       (dout),
    .sync     (sync),
    .rdy_in   (rdyIn),
    .rdy      (rdy),
    .DB       (db),
    .mem_req  (memReq),
    .mem_we   (memWe),
    .mem_fetch(memFetch),
    .mem_addr (memAddr),
    .mem_wdata(memWdata),
    .mem_ack  (memAck),
    .mem_rdata(rdata),
    .bus_err  (busErr),
    .err_clr  (errClr)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds one vector: inputs first, then the outputs expected after the edge.
  function automatic vec_t mk(
    input logic rst, input logic rIn, input logic [15:0] a, input logic w,
    input logic [7:0] d, input logic s, input logic ak, input logic [7:0] rd,
    input logic clr,
    input logic eR, input logic eQ, input logic eW, input logic eF,
    input logic [15:0] eA, input logic [7:0] eD, input logic [7:0] eB,
    input logic eE);
    vec_t v;
    v.rst = rst; v.rdyIn = rIn; v.ab = a; v.we = w; v.dout = d; v.sync = s;
    v.ack = ak; v.rdata = rd; v.errClr = clr;
    v.eRdy = eR; v.eReq = eQ; v.eWe = eW; v.eFetch = eF; v.eAddr = eA;
    v.eWdata = eD; v.eDb = eB; v.eErr = eE;
    return v;
  endfunction

  // Drives one vector's inputs and advances past one rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset  = v.rst;
    rdyIn  = v.rdyIn;
    ab     = v.ab;
    we     = v.we;
    dout   = v.dout;
    sync   = v.sync;
    memAck = v.ack;
    rdata  = v.rdata;
    errClr = v.errClr;
    @(posedge clk);
    #1;
  endtask

  // Compares every DUT output against the vector's expected values.
  task automatic checkOutput(input vec_t v, input string tag);
    logic [35:0] actVal;
    logic [35:0] expVal;
    actVal = {rdy, memReq, memWe, memFetch, memAddr, memWdata, db, busErr};
    expVal = {v.eRdy, v.eReq, v.eWe, v.eFetch, v.eAddr, v.eWdata, v.eDb, v.eErr};
    total++;
    if (actVal !== expVal) begin
      bad++;
      $display("[TB] FAIL %s: got rdy=%b req=%b we=%b fetch=%b addr=%h wdata=%h db=%h err=%b, expected rdy=%b req=%b we=%b fetch=%b addr=%h wdata=%h db=%h err=%b",
               tag, rdy, memReq, memWe, memFetch, memAddr, memWdata, db, busErr,
               v.eRdy, v.eReq, v.eWe, v.eFetch, v.eAddr, v.eWdata, v.eDb, v.eErr);
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b0; rdyIn = 1'b0; ab = '0; we = 1'b0; dout = '0; sync = 1'b0;
    memAck = 1'b0; rdata = '0; errClr = 1'b0;

    //               rst rIn ab       we dout   sy ak rdata  clr | rdy req we fe addr     wdata  db     err
    // reset state
    vecs.push_back(mk(0, 0, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 0,   0, 0, 0, 0, 16'h0000, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 0,   1, 0, 0, 0, 16'h0000, 8'h00, 8'h00, 0));
    // zero-wait reads, rdy high every second clock
    vecs.push_back(mk(1, 1, 16'hFFFC, 0, 8'h00, 0, 0, 8'h00, 0,   0, 1, 0, 0, 16'hFFFC, 8'h00, 8'h00, 0));
    vecs.push_back(mk(1, 1, 16'hFFFC, 0, 8'h00, 0, 1, 8'h34, 0,   1, 0, 0, 0, 16'hFFFC, 8'h00, 8'h34, 0));
    vecs.push_back(mk(1, 1, 16'hFFFC, 0, 8'h00, 0, 0, 8'h00, 0,   0, 1, 0, 0, 16'hFFFC, 8'h00, 8'h34, 0));
    vecs.push_back(mk(1, 1, 16'hFFFC, 0, 8'h00, 0, 1, 8'h35, 0,   1, 0, 0, 0, 16'hFFFC, 8'h00, 8'h35, 0));
    // 3-wait opcode fetch; core bus changes while waiting, request must not
    vecs.push_back(mk(1, 1, 16'h0200, 0, 8'h00, 1, 0, 8'h00, 0,   0, 1, 0, 1, 16'h0200, 8'h00, 8'h35, 0));
    repeat (2)
      vecs.push_back(mk(1, 1, 16'h1111, 1, 8'hFF, 0, 0, 8'h00, 0, 0, 1, 0, 1, 16'h0200, 8'h00, 8'h35, 0));
    vecs.push_back(mk(1, 1, 16'h1111, 1, 8'hFF, 0, 1, 8'hA9, 0,   1, 0, 0, 1, 16'h0200, 8'h00, 8'hA9, 0));
    // write leaves DB unchanged
    vecs.push_back(mk(1, 1, 16'h01FF, 1, 8'h5A, 0, 0, 8'h00, 0,   0, 1, 1, 0, 16'h01FF, 8'h5A, 8'hA9, 0));
    vecs.push_back(mk(1, 1, 16'h01FF, 1, 8'h5A, 0, 1, 8'hEE, 0,   1, 0, 1, 0, 16'h01FF, 8'h5A, 8'hA9, 0));
    // rdy_in low in READY: no request; spurious ack ignored
    repeat (2)
      vecs.push_back(mk(1, 0, 16'h3333, 0, 8'h11, 1, 0, 8'h00, 0, 0, 0, 1, 0, 16'h01FF, 8'h5A, 8'hA9, 0));
    vecs.push_back(mk(1, 0, 16'h3333, 0, 8'h11, 1, 1, 8'h77, 0,   0, 0, 1, 0, 16'h01FF, 8'h5A, 8'hA9, 0));
    vecs.push_back(mk(1, 0, 16'h3333, 0, 8'h11, 1, 0, 8'h00, 0,   0, 0, 1, 0, 16'h01FF, 8'h5A, 8'hA9, 0));
    // rdy_in low when the ack arrives
    vecs.push_back(mk(1, 1, 16'h0400, 0, 8'h00, 0, 0, 8'h00, 0,   0, 1, 0, 0, 16'h0400, 8'h00, 8'hA9, 0));
    vecs.push_back(mk(1, 0, 16'h0400, 0, 8'h00, 0, 1, 8'h5C, 0,   0, 0, 0, 0, 16'h0400, 8'h00, 8'h5C, 0));
    vecs.push_back(mk(1, 0, 16'h0400, 0, 8'h00, 0, 0, 8'h00, 0,   0, 0, 0, 0, 16'h0400, 8'h00, 8'h5C, 0));
    // read timeout after 4 wait cycles
    vecs.push_back(mk(1, 1, 16'h0500, 0, 8'h00, 0, 0, 8'h00, 0,   0, 1, 0, 0, 16'h0500, 8'h00, 8'h5C, 0));
    repeat (3)
      vecs.push_back(mk(1, 1, 16'h0500, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 16'h0500, 8'h00, 8'h5C, 0));
    vecs.push_back(mk(1, 1, 16'h0500, 0, 8'h00, 0, 0, 8'h00, 0,   1, 0, 0, 0, 16'h0500, 8'h00, 8'hFF, 1));
    vecs.push_back(mk(1, 0, 16'h0500, 0, 8'h00, 0, 0, 8'h00, 1,   0, 0, 0, 0, 16'h0500, 8'h00, 8'hFF, 0));
    // timeout and err_clr together: set wins
    vecs.push_back(mk(1, 1, 16'h0600, 0, 8'h00, 0, 0, 8'h00, 0,   0, 1, 0, 0, 16'h0600, 8'h00, 8'hFF, 0));
    repeat (3)
      vecs.push_back(mk(1, 1, 16'h0600, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 0, 0, 16'h0600, 8'h00, 8'hFF, 0));
    vecs.push_back(mk(1, 1, 16'h0600, 0, 8'h00, 0, 0, 8'h00, 1,   1, 0, 0, 0, 16'h0600, 8'h00, 8'hFF, 1));
    vecs.push_back(mk(1, 0, 16'h0600, 0, 8'h00, 0, 0, 8'h00, 1,   0, 0, 0, 0, 16'h0600, 8'h00, 8'hFF, 0));
    // ack on the terminal cycle wins over the timeout
    vecs.push_back(mk(1, 1, 16'h0700, 0, 8'h00, 0, 0, 8'h00, 0,   0, 1, 0, 0, 16'h0700, 8'h00, 8'hFF, 0));
    repeat (3)
      vecs.push_back(mk(1, 1, 16'h0700, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 16'h0700, 8'h00, 8'hFF, 0));
    vecs.push_back(mk(1, 1, 16'h0700, 0, 8'h00, 0, 1, 8'h42, 0,   1, 0, 0, 0, 16'h0700, 8'h00, 8'h42, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("row%0d", i));
    end

    // Reset in the middle of a write access, then a late ack.
    v = mk(1, 1, 16'h0800, 1, 8'hC3, 0, 0, 8'h00, 0,   0, 1, 1, 0, 16'h0800, 8'hC3, 8'h42, 0);
    applyStimulus(v);
    checkOutput(v, "rst_launch");
    v = mk(0, 0, 16'h0800, 1, 8'hC3, 0, 0, 8'h00, 0,   0, 0, 0, 0, 16'h0000, 8'h00, 8'h00, 0);
    applyStimulus(v);
    checkOutput(v, "rst_mid_access");
    v = mk(1, 0, 16'h0800, 0, 8'h00, 0, 1, 8'h99, 0,   0, 0, 0, 0, 16'h0000, 8'h00, 8'h00, 0);
    applyStimulus(v);
    checkOutput(v, "late_ack");

    // Write timeout: error flagged but DB left alone.
    v = mk(1, 1, 16'h0900, 1, 8'h12, 0, 0, 8'h00, 0,   0, 1, 1, 0, 16'h0900, 8'h12, 8'h00, 0);
    applyStimulus(v);
    checkOutput(v, "wto_launch");
    for (int i = 0; i < 4; i++) begin
      if (i == 3)
        v = mk(1, 1, 16'h0900, 1, 8'h12, 0, 0, 8'h00, 0, 1, 0, 1, 0, 16'h0900, 8'h12, 8'h00, 1);
      else
        v = mk(1, 1, 16'h0900, 1, 8'h12, 0, 0, 8'h00, 0, 0, 1, 1, 0, 16'h0900, 8'h12, 8'h00, 0);
      applyStimulus(v);
      checkOutput(v, $sformatf("wto_wait%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
